// File: rtl/ahb_master_pack.sv
// Shared types for the AHB master UI arbiter.
//   t_hsize     : AHB transfer size encoding (HSIZE).
//   t_arb_state : arbiter FSM state, with ST_IDLE / ST_BURST constants.
package ahb_master_pack;

  typedef logic [2:0] t_hsize;

  localparam t_hsize HSIZE_BYTE  = 3'd0;
  localparam t_hsize HSIZE_HALF  = 3'd1;
  localparam t_hsize HSIZE_WORD  = 3'd2;
  localparam t_hsize HSIZE_DWORD = 3'd3;

  typedef logic [0:0] t_arb_state;

  localparam t_arb_state ST_IDLE  = 1'b0;
  localparam t_arb_state ST_BURST = 1'b1;

endpackage

// File: rtl/ahb_master_ui_arb_tag_fifo.sv
// Owner-tag FIFO: remembers which requester issued each outstanding read beat so
// the matching response can be routed back in order.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : store push_tag (ignored while full)
//   pop        : discard the head entry (ignored while empty)
//   pop_tag    : head entry, valid whenever empty is 0
//   full/empty : derived from the registered occupancy count
module ahb_master_ui_arb_tag_fifo #(
  parameter int TAG_DEPTH = 8,
  parameter int TAG_WDT   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [TAG_WDT-1:0] push_tag,
  input  logic               pop,
  output logic [TAG_WDT-1:0] pop_tag,
  output logic               full,
  output logic               empty
);

  localparam int PTR_WDT = $clog2(TAG_DEPTH);

  logic [TAG_WDT-1:0] mem_q [TAG_DEPTH];
  logic [PTR_WDT-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_WDT:0]   count_q;
  logic               push_ok, pop_ok;

  assign full    = (count_q == (PTR_WDT + 1)'(TAG_DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign pop_tag = mem_q[rd_ptr_q];

  // Storage needs no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_tag;
  end

  // Pointers wrap naturally because TAG_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ahb_master_ui_arb.sv
// Multi-requester arbiter in front of an AHB master user interface. Grants one
// burst at a time, forwards it to the master UI, and routes read responses back
// to the requester that issued them via an owner-tag FIFO.
// Config macro: AHB_MASTER_UI_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins); the default build arbitrates round-robin.
// Ports:
//   i_hclk, i_hreset_n            : clock, asynchronous active-low reset
//   i_req_* / o_req_ready         : per-requester burst command handshake
//   i_req_wdata/i_req_wdav/o_req_wack : per-requester write data stream
//   o_rsp_data/o_rsp_addr/o_rsp_dav   : read response (one-hot valid)
//   o_idle ... o_wr_data_dav, i_stall : master UI command side
//   i_data/i_addr/i_dav           : master UI read response
//   o_err                         : sticky, a response arrived with no owner tag
module ahb_master_ui_arb
  import ahb_master_pack::*;
#(
  parameter int NREQ      = 2,
  parameter int DATA_WDT  = 32,
  parameter int BEAT_WDT  = 32,
  parameter int TAG_DEPTH = 8
) (
  input  logic                               i_hclk,
  input  logic                               i_hreset_n,
  input  logic [NREQ-1:0]                    i_req_valid,
  output logic [NREQ-1:0]                    o_req_ready,
  input  logic [NREQ-1:0][31:0]              i_req_addr,
  input  t_hsize [NREQ-1:0]                  i_req_size,
  input  logic [NREQ-1:0]                    i_req_wr,
  input  logic [NREQ-1:0][BEAT_WDT-1:0]      i_req_len,
  input  logic [NREQ-1:0][DATA_WDT-1:0]      i_req_wdata,
  input  logic [NREQ-1:0]                    i_req_wdav,
  output logic [NREQ-1:0]                    o_req_wack,
  output logic [DATA_WDT-1:0]                o_rsp_data,
  output logic [31:0]                        o_rsp_addr,
  output logic [NREQ-1:0]                    o_rsp_dav,
  output logic                               o_idle,
  output logic                               o_first_xfer,
  output logic                               o_wr,
  output logic                               o_rd,
  output logic [31:0]                        o_addr,
  output t_hsize                             o_size,
  output logic [BEAT_WDT-1:0]                o_min_len,
  output logic [DATA_WDT-1:0]                o_wr_data,
  output logic                               o_wr_data_dav,
  input  logic                               i_stall,
  input  logic [DATA_WDT-1:0]                i_data,
  input  logic [31:0]                        i_addr,
  input  logic                               i_dav,
  output logic                               o_err
);

  localparam int TAG_WDT = $clog2(NREQ);

  t_arb_state          state_q;
  logic [TAG_WDT-1:0]  gnt_q, win;
  logic                any_req, grant, in_burst, beat;
  logic [31:0]         addr_q;
  t_hsize              size_q;
  logic                wr_q, first_q, err_q;
  logic [BEAT_WDT-1:0] len_q, cnt_q, len_eff;
  logic [NREQ-1:0]     gnt_oh, win_oh, tag_oh;
  logic                fifo_full, fifo_empty;
  logic [TAG_WDT-1:0]  pop_tag;

  // Arbitration
`ifdef AHB_MASTER_UI_ARB_FIXED_PRIO_EN
  always_comb begin
    win     = '0;
    any_req = 1'b0;
    // Descending scan so the lowest valid index is the last (winning) write.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        win     = TAG_WDT'(i);
        any_req = 1'b1;
      end
    end
  end
`else
  logic [TAG_WDT-1:0] rr_ptr_q;

  always_comb begin
    int idx;
    win     = '0;
    any_req = 1'b0;
    // Search starts at the pointer and wraps; first valid hit wins.
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!any_req && i_req_valid[idx]) begin
        win     = TAG_WDT'(idx);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      rr_ptr_q <= '0;
    end else if (grant) begin
      rr_ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end
`endif

  assign in_burst = (state_q == ST_BURST);
  assign grant    = ~in_burst & any_req;
  assign len_eff  = (i_req_len[win] == '0) ? BEAT_WDT'(1) : i_req_len[win];

  always_comb begin
    win_oh         = '0;
    win_oh[win]    = 1'b1;
    gnt_oh         = '0;
    gnt_oh[gnt_q]  = 1'b1;
    tag_oh         = '0;
    tag_oh[pop_tag] = 1'b1;
  end

  // Command side
  assign o_idle        = ~in_burst;
  assign o_first_xfer  = first_q;
  assign o_wr          = in_burst & wr_q;
  // Read issue is gated by the FIFO's registered occupancy, so a pushed beat
  // always has room for its tag.
  assign o_rd          = in_burst & ~wr_q & ~fifo_full;
  assign o_addr        = addr_q;
  assign o_size        = size_q;
  assign o_min_len     = len_q;
  assign o_wr_data     = o_wr ? i_req_wdata[gnt_q] : '0;
  assign o_wr_data_dav = o_wr & i_req_wdav[gnt_q];
  assign beat          = in_burst & ~i_stall & (o_rd | o_wr_data_dav);

  assign o_req_ready   = grant ? win_oh : '0;
  assign o_req_wack    = (beat & wr_q) ? gnt_oh : '0;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else if (grant) begin
      state_q <= ST_BURST;
      gnt_q   <= win;
      addr_q  <= i_req_addr[win];
      size_q  <= i_req_size[win];
      wr_q    <= i_req_wr[win];
      len_q   <= len_eff;
      cnt_q   <= len_eff;
      first_q <= 1'b1;
    end else if (beat) begin
      first_q <= 1'b0;
      cnt_q   <= cnt_q - 1'b1;
      if (cnt_q == BEAT_WDT'(1)) state_q <= ST_IDLE;
    end
  end

  // Response side
  ahb_master_ui_arb_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH),
    .TAG_WDT   (TAG_WDT)
  ) u_tag_fifo (
    .clk      (i_hclk),
    .rst_n    (i_hreset_n),
    .push     (beat & ~wr_q),
    .push_tag (gnt_q),
    .pop      (i_dav),
    .pop_tag  (pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign o_rsp_data = i_data;
  assign o_rsp_addr = i_addr;
  assign o_rsp_dav  = (i_dav & ~fifo_empty) ? tag_oh : '0;
  assign o_err      = err_q;

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      err_q <= 1'b0;
    end else if (i_dav & fifo_empty) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_master_ui_arb.sv
// Directed bench for ahb_master_ui_arb (default round-robin build, NREQ=2,
// TAG_DEPTH=8).
module tb_ahb_master_ui_arb;
  import ahb_master_pack::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_wr, req_wdav, req_wack, rsp_dav;
  logic [1:0][31:0]  req_addr, req_len, req_wdata;
  t_hsize [1:0]      req_size;
  logic [31:0]       rsp_data, rsp_addr, o_addr, o_min_len, o_wr_data, i_data, i_addr;
  t_hsize            o_size;
  logic              o_idle, o_first_xfer, o_wr, o_rd, o_wr_data_dav, o_err;
  logic              i_stall, i_dav;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahb_master_ui_arb dut (
    .i_hclk        (clk),
    .i_hreset_n    (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_size    (req_size),
    .i_req_wr      (req_wr),
    .i_req_len     (req_len),
    .i_req_wdata   (req_wdata),
    .i_req_wdav    (req_wdav),
    .o_req_wack    (req_wack),
    .o_rsp_data    (rsp_data),
    .o_rsp_addr    (rsp_addr),
    .o_rsp_dav     (rsp_dav),
    .o_idle        (o_idle),
    .o_first_xfer  (o_first_xfer),
    .o_wr          (o_wr),
    .o_rd          (o_rd),
    .o_addr        (o_addr),
    .o_size        (o_size),
    .o_min_len     (o_min_len),
    .o_wr_data     (o_wr_data),
    .o_wr_data_dav (o_wr_data_dav),
    .i_stall       (i_stall),
    .i_data        (i_data),
    .i_addr        (i_addr),
    .i_dav         (i_dav),
    .o_err         (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow after a further #1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, firsts, wacks, ng, run, pops;
    logic [1:0] grants [4];
    logic [4:0] wpat;

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_size = '0; req_wr = '0;
    req_len = '0; req_wdata = '0; req_wdav = '0; i_stall = 1'b0;
    i_data = '0; i_addr = '0; i_dav = 1'b0;

    // Reset state
    #22;
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_wr", 32'(o_wr), 32'd0);
    chk("rst_first", 32'(o_first_xfer), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_rsp_dav", 32'(rsp_dav), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single read, req0, len 4
    req_valid[0] = 1'b1; req_addr[0] = 32'h100; req_len[0] = 32'd4;
    req_wr[0] = 1'b0; req_size[0] = HSIZE_WORD;
    #1;
    chk("rd_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("rd_min_len", o_min_len, 32'd4);
    chk("rd_size", 32'(o_size), 32'(HSIZE_WORD));
    beats = 0; firsts = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_idle) break;
      if (o_rd) beats++;
      if (o_first_xfer) firsts++;
      chk("rd_addr", o_addr, 32'h100);
      tick();
    end
    chk("rd_beats", 32'(beats), 32'd4);
    chk("rd_first_cycles", 32'(firsts), 32'd1);
    chk("rd_back_idle", 32'(o_idle), 32'd1);
    for (int k = 0; k < 4; k++) begin
      i_dav = 1'b1; i_data = 32'hD0 + 32'(k); i_addr = 32'h100 + 32'(4 * k);
      #1;
      chk("rd_rsp_dav", 32'(rsp_dav), 32'b01);
      chk("rd_rsp_data", rsp_data, 32'hD0 + 32'(k));
      tick();
    end
    i_dav = 1'b0;
    chk("rd_no_err", 32'(o_err), 32'd0);

    // Gapped write, req1, len 3
    req_valid[1] = 1'b1; req_addr[1] = 32'h200; req_len[1] = 32'd3; req_wr[1] = 1'b1;
    #1;
    chk("wr_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    wpat = 5'b10101;
    wacks = 0;
    for (int c = 0; c < 5; c++) begin
      req_wdav[1] = wpat[c];
      req_wdata[1] = 32'hA000 + 32'(c);
      #1;
      chk("wr_addr", o_addr, 32'h200);
      chk("wr_o_wr", 32'(o_wr), 32'd1);
      chk("wr_wack", 32'(req_wack), wpat[c] ? 32'b10 : 32'b00);
      chk("wr_data", o_wr_data, 32'hA000 + 32'(c));
      if (req_wack[1]) wacks++;
      tick();
    end
    req_wdav = '0;
    chk("wr_wack_count", 32'(wacks), 32'd3);
    chk("wr_back_idle", 32'(o_idle), 32'd1);

    // Contention: both valid, round-robin alternates; req0 len 0 acts as 1 beat
    req_wr = '0; req_len[0] = 32'd0; req_len[1] = 32'd1;
    req_addr[0] = 32'h10; req_addr[1] = 32'h20;
    req_valid = 2'b11;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        grants[ng] = req_ready;
        ng++;
      end
      if (!o_idle) chk("ct_min_len", o_min_len, 32'd1);
      tick();
    end
    req_valid = '0;
    chk("ct_ngrants", 32'(ng), 32'd4);
    chk("ct_g0", 32'(grants[0]), 32'b01);
    chk("ct_g1", 32'(grants[1]), 32'b10);
    chk("ct_g2", 32'(grants[2]), 32'b01);
    chk("ct_g3", 32'(grants[3]), 32'b10);
    chk("ct_last_burst", 32'(o_rd), 32'd1);
    tick();
    chk("ct_idle", 32'(o_idle), 32'd1);
    for (int k = 0; k < 4; k++) begin
      i_dav = 1'b1;
      #1;
      chk("ct_rsp_order", 32'(rsp_dav), (k % 2 == 0) ? 32'b01 : 32'b10);
      tick();
    end
    i_dav = 1'b0;

    // Tag FIFO full: read len 12, no responses until the gap appears
    req_valid[0] = 1'b1; req_addr[0] = 32'h300; req_len[0] = 32'd12;
    #1;
    chk("ff_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    run = 0;
    for (int c = 0; c < 20; c++) begin
      if (!o_rd) break;
      run++;
      tick();
    end
    chk("ff_run", 32'(run), 32'd8);
    chk("ff_in_burst", 32'(o_idle), 32'd0);
    tick();
    chk("ff_gap_holds", 32'(o_rd), 32'd0);
    i_dav = 1'b1;
    #1;
    chk("ff_first_rsp", 32'(rsp_dav), 32'b01);
    tick();
    i_dav = 1'b0;
    #1;
    chk("ff_resume", 32'(o_rd), 32'd1);
    pops = 1; beats = 0;
    for (int c = 0; c < 40; c++) begin
      i_dav = (pops < 12);
      #1;
      if (o_rd) beats++;
      if (rsp_dav == 2'b01) pops++;
      tick();
      if (o_idle && pops == 12) break;
    end
    i_dav = 1'b0;
    chk("ff_rest_beats", 32'(beats), 32'd4);
    chk("ff_pops", 32'(pops), 32'd12);
    chk("ff_no_err", 32'(o_err), 32'd0);

    // Response with empty FIFO
    i_dav = 1'b1;
    #1;
    chk("er_no_rsp", 32'(rsp_dav), 32'd0);
    tick();
    i_dav = 1'b0;
    #1;
    chk("er_err_set", 32'(o_err), 32'd1);
    tick();
    chk("er_err_sticky", 32'(o_err), 32'd1);

    // Reset mid-burst: leave 2 read tags outstanding, then start a write
    req_valid[0] = 1'b1; req_addr[0] = 32'h500; req_len[0] = 32'd2;
    #1;
    chk("rs_rd_ready", 32'(req_ready), 32'b01);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    chk("rs_rd_done", 32'(o_idle), 32'd1);
    req_valid[1] = 1'b1; req_addr[1] = 32'h400; req_len[1] = 32'd5; req_wr[1] = 1'b1;
    req_wdav[1] = 1'b1;
    #1;
    chk("rs_wr_ready", 32'(req_ready), 32'b10);
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("rs_wack_pre", 32'(req_wack), 32'b10);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rs_idle", 32'(o_idle), 32'd1);
    chk("rs_err_clr", 32'(o_err), 32'd0);
    chk("rs_wack_off", 32'(req_wack), 32'd0);
    chk("rs_wr_off", 32'(o_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rs_post_idle", 32'(o_idle), 32'd1);
    chk("rs_post_wack", 32'(req_wack), 32'd0);
    i_dav = 1'b1;
    #1;
    chk("rs_post_rsp", 32'(rsp_dav), 32'd0);
    tick();
    i_dav = 1'b0;
    req_wdav = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
